ex_mult_pipe: RTL and testbench

- Parametrised, pipelined RV32M multiply functional unit for the execute stage; successor to the single-cycle combinational multiply path.
- Receives issued MUL/MULH/MULHSU/MULHU ops from issue with destination physical tag and ROB index. Produces a tagged result toward complete/CDB arbitration.
- Supports back-pressure from the CDB grant, bubble collapsing and whole-pipe squash on branch mispredict.

---
 rtl/ex_mult_pipe.sv | 150 +++++++++++++++
 tb/tb_ex_mult_pipe.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mult_pipe.sv
// Pipelined RV32M multiply unit (MUL/MULH/MULHSU/MULHU).
// Each stage folds one CH-bit multiplier chunk into a running 2*XLEN product.
// Stage valids bubble-collapse toward the output and stall on CDB back-pressure.

// One partial-product step: prod + (mcand * chunk) << SHIFT, modulo 2^W2.
module ex_mult_step #(
  parameter int W2    = 64,
  parameter int CH    = 16,
  parameter int SHIFT = 0
) (
  input  logic [W2-1:0] mcand,
  input  logic [CH-1:0] chunk,
  input  logic [W2-1:0] prod,
  output logic [W2-1:0] nxt_prod
);
  logic [W2-1:0] chunk_x;

  assign chunk_x  = W2'(chunk);
  assign nxt_prod = prod + ((mcand * chunk_x) << SHIFT);
endmodule

module ex_mult_pipe #(
  parameter int XLEN       = 32,
  parameter int NUM_STAGES = 4,
  parameter int TAG_W      = 6,
  parameter int ROB_W      = 5
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            squash,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [1:0]                      in_func,
  input  logic [XLEN-1:0]                 in_rs1,
  input  logic [XLEN-1:0]                 in_rs2,
  input  logic [TAG_W-1:0]                in_tag,
  input  logic [ROB_W-1:0]                in_rob,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [XLEN-1:0]                 out_result,
  output logic [TAG_W-1:0]                out_tag,
  output logic [ROB_W-1:0]                out_rob,
  output logic [$clog2(NUM_STAGES+1)-1:0] busy_cnt
);
  localparam int W2 = 2 * XLEN;
  localparam int CH = W2 / NUM_STAGES;
  localparam int CW = $clog2(NUM_STAGES + 1);

  typedef struct packed {
    logic [1:0]       func;
    logic [TAG_W-1:0] tag;
    logic [ROB_W-1:0] rob;
  } meta_t;

  logic [NUM_STAGES:1] vld_pipe, vld_nxt, free;
  logic [CW-1:0]       busy_nxt;
  logic                accept;
  logic                sx1, sx2;
  logic [W2-1:0]       rs1_x, rs2_x;

  // MULH/MULHSU treat rs1 as signed; only MULH treats rs2 as signed.
  assign sx1    = (in_func[1] ^ in_func[0]) & in_rs1[XLEN-1];
  assign sx2    = (in_func == 2'd1) & in_rs2[XLEN-1];
  assign rs1_x  = {{XLEN{sx1}}, in_rs1};
  assign rs2_x  = {{XLEN{sx2}}, in_rs2};
  assign accept = in_valid && in_ready && !squash;
  assign in_ready = free[1];

  for (genvar k = 1; k <= NUM_STAGES; k++) begin : g_stg
    // multiplier bits still unconsumed when an op enters this stage
    localparam int SRW = W2 - (k - 1) * CH;

    meta_t          src_meta, meta_q;
    logic [W2-1:0]  src_mcand, src_prod, nxt_prod, prod_q;
    logic [SRW-1:0] src_mplier;

    // A stage may load whenever some stage at or beyond it is empty, or the head drains.
    assign free[k] = out_ready || !(&vld_pipe[NUM_STAGES:k]);

    if (k == 1) begin : g_first
      assign src_meta   = {in_func, in_tag, in_rob};
      assign src_mcand  = rs1_x;
      assign src_mplier = rs2_x;
      assign src_prod   = '0;
    end else begin : g_chain
      assign src_meta   = g_stg[k-1].meta_q;
      assign src_mcand  = g_stg[k-1].g_carry.mcand_q;
      assign src_mplier = g_stg[k-1].g_carry.mplier_q;
      assign src_prod   = g_stg[k-1].prod_q;
    end

    ex_mult_step #(.W2(W2), .CH(CH), .SHIFT((k - 1) * CH)) u_step (
      .mcand    (src_mcand),
      .chunk    (src_mplier[CH-1:0]),
      .prod     (src_prod),
      .nxt_prod (nxt_prod)
    );

    // Stage payload; loads on free so a stalled head holds its result stable.
    always_ff @(posedge clock) begin
      if (free[k]) begin
        meta_q <= src_meta;
        prod_q <= nxt_prod;
      end
    end

    if (k < NUM_STAGES) begin : g_carry
      logic [W2-1:0]     mcand_q;
      logic [SRW-CH-1:0] mplier_q;

      // Operands still needed by later stages; the consumed chunk is dropped.
      always_ff @(posedge clock) begin
        if (free[k]) begin
          mcand_q  <= src_mcand;
          mplier_q <= src_mplier[SRW-1:CH];
        end
      end
    end
  end

  // Next valid vector: shift into free stages, squash wipes everything.
  always_comb begin
    vld_nxt = vld_pipe;
    if (free[1]) vld_nxt[1] = accept;
    for (int k = 2; k <= NUM_STAGES; k++)
      if (free[k]) vld_nxt[k] = vld_pipe[k-1];
    if (squash) vld_nxt = '0;
    busy_nxt = '0;
    for (int k = 1; k <= NUM_STAGES; k++)
      busy_nxt = busy_nxt + CW'(vld_nxt[k]);
  end

  // Control state: only valids and occupancy count need reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_pipe <= '0;
      busy_cnt <= '0;
    end else begin
      vld_pipe <= vld_nxt;
      busy_cnt <= busy_nxt;
    end
  end

  assign out_valid  = vld_pipe[NUM_STAGES];
  assign out_tag    = g_stg[NUM_STAGES].meta_q.tag;
  assign out_rob    = g_stg[NUM_STAGES].meta_q.rob;
  assign out_result = (g_stg[NUM_STAGES].meta_q.func == 2'd0) ?
                      g_stg[NUM_STAGES].prod_q[XLEN-1:0] :
                      g_stg[NUM_STAGES].prod_q[W2-1:XLEN];
endmodule

// File: tb/tb_ex_mult_pipe.sv
// Scoreboard bench for ex_mult_pipe: main 4-stage instance plus 1/2/8-stage copies.
module tb_ex_mult_pipe;
  typedef struct {
    logic [31:0] res;
    logic [5:0]  tag;
    logic [4:0]  rob;
    int          due;
  } exp_t;

  logic        clock = 0, reset = 0, squash = 0;
  logic        in_valid = 0, in_ready, out_valid, out_ready = 1;
  logic [1:0]  in_func = 0;
  logic [31:0] in_rs1 = 0, in_rs2 = 0, out_result;
  logic [5:0]  in_tag = 0, out_tag;
  logic [4:0]  in_rob = 0, out_rob;
  logic [2:0]  busy_cnt;

  logic        sw_valid = 0;
  logic [1:0]  sw_func = 0;
  logic [31:0] sw_rs1 = 0, sw_rs2 = 0, sw_exp = 0;
  logic [5:0]  sw_tag = 0;
  logic [4:0]  sw_rob = 0;

  int   checks = 0, errors = 0, cyc = 0;
  exp_t sb[$];
  exp_t me;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  ex_mult_pipe #(.XLEN(32), .NUM_STAGES(4), .TAG_W(6), .ROB_W(5)) u_dut (
    .clock(clock), .reset(reset), .squash(squash),
    .in_valid(in_valid), .in_ready(in_ready), .in_func(in_func),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag), .in_rob(in_rob),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_rob(out_rob), .busy_cnt(busy_cnt)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // Main-instance monitor: pops the scoreboard on every output handshake.
  always @(negedge clock) begin
    #2;
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out got tag %0d res %0h want nothing", out_tag, out_result);
      end else begin
        me = sb.pop_front();
        chk("result", out_result, me.res);
        chk("tag", out_tag, me.tag);
        chk("rob", out_rob, me.rob);
        if (me.due >= 0) chk("latency", cyc, me.due);
      end
    end
  end

  // Parameter sweep copies share one stimulus stream with out_ready tied high.
  for (genvar i = 0; i < 3; i++) begin : g_sw
    localparam int NS = (i == 0) ? 1 : ((i == 1) ? 2 : 8);
    logic                     rdy, ov;
    logic [31:0]              res;
    logic [5:0]               tg;
    logic [4:0]               rb;
    logic [$clog2(NS+1)-1:0]  bc;
    exp_t q[$];
    exp_t se;

    ex_mult_pipe #(.XLEN(32), .NUM_STAGES(NS), .TAG_W(6), .ROB_W(5)) u_sw (
      .clock(clock), .reset(reset), .squash(1'b0),
      .in_valid(sw_valid), .in_ready(rdy), .in_func(sw_func),
      .in_rs1(sw_rs1), .in_rs2(sw_rs2), .in_tag(sw_tag), .in_rob(sw_rob),
      .out_valid(ov), .out_ready(1'b1), .out_result(res),
      .out_tag(tg), .out_rob(rb), .busy_cnt(bc)
    );

    always @(posedge clock) begin
      if (reset && sw_valid) begin
        chk("sw_in_ready", rdy, 1);
        q.push_back('{sw_exp, sw_tag, sw_rob, cyc + NS});
      end
    end

    always @(negedge clock) begin
      #2;
      if (reset && ov) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sw_unexpected NS=%0d got tag %0d want nothing", NS, tg);
        end else begin
          se = q.pop_front();
          chk($sformatf("sw%0d_result", NS), res, se.res);
          chk($sformatf("sw%0d_tag", NS), tg, se.tag);
          chk($sformatf("sw%0d_rob", NS), rb, se.rob);
          chk($sformatf("sw%0d_latency", NS), cyc, se.due);
        end
      end
    end
  end

  // Present one op until accepted (bounded); push its expectation on accept.
  task automatic issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] t, input logic [4:0] r, input logic [31:0] x,
                       input bit lat);
    bit acc = 0;
    int due;
    @(negedge clock);
    in_valid = 1; in_func = f; in_rs1 = a; in_rs2 = b; in_tag = t; in_rob = r;
    for (int n = 0; n < 50 && !acc; n++) begin
      #1;
      acc = in_ready;
      due = lat ? cyc + 4 : -1;
      @(posedge clock);
      if (acc) sb.push_back('{x, t, r, due});
      else @(negedge clock);
    end
    #1;
    in_valid = 0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL issue_timeout got no accept want accept for tag %0d", t);
    end
  endtask

  task automatic sw_issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] t, input logic [4:0] r, input logic [31:0] x);
    @(negedge clock);
    sw_valid = 1; sw_func = f; sw_rs1 = a; sw_rs2 = b; sw_tag = t; sw_rob = r; sw_exp = x;
    @(posedge clock);
    #1;
    sw_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (2) @(negedge clock);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy_cnt, 0);
    @(negedge clock);
    reset = 1;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // basic MUL with latency check
    issue(2'd0, 32'd7, 32'd6, 6'd33, 5'd2, 32'd42, 1);
    repeat (6) @(posedge clock);
    @(negedge clock); #1;
    chk("basic_busy_idle", busy_cnt, 0);

    // signed variants, back to back
    issue(2'd1, 32'hFFFFFFFF, 32'h2, 6'd10, 5'd10, 32'hFFFFFFFF, 1);
    issue(2'd2, 32'hFFFFFFFF, 32'h2, 6'd11, 5'd11, 32'hFFFFFFFF, 1);
    issue(2'd3, 32'hFFFFFFFF, 32'h2, 6'd12, 5'd12, 32'h00000001, 1);
    issue(2'd0, 32'hFFFFFFFF, 32'h2, 6'd13, 5'd13, 32'hFFFFFFFE, 1);
    issue(2'd1, 32'h80000000, 32'h80000000, 6'd14, 5'd14, 32'h40000000, 1);
    issue(2'd2, 32'h80000000, 32'h80000000, 6'd15, 5'd15, 32'hC0000000, 1);
    issue(2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd16, 5'd16, 32'hFFFFFFFE, 1);
    issue(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd17, 5'd17, 32'h00000001, 1);
    issue(2'd3, 32'h00010000, 32'h00010000, 6'd18, 5'd18, 32'h00000001, 1);
    repeat (6) @(posedge clock);

    // back-to-back with stall
    @(negedge clock);
    out_ready = 0;
    for (int i = 0; i < 4; i++)
      issue(2'd0, 32'(i + 1), 32'd3, 6'(20 + i), 5'(i), 32'(3 * (i + 1)), 0);
    @(negedge clock);
    in_valid = 1; in_func = 0; in_rs1 = 5; in_rs2 = 3; in_tag = 24; in_rob = 4;
    #1;
    chk("stall_in_ready", in_ready, 0);
    chk("stall_busy", busy_cnt, 4);
    chk("stall_out_valid", out_valid, 1);
    chk("stall_result", out_result, 3);
    chk("stall_tag", out_tag, 20);
    repeat (2) begin
      @(negedge clock); #1;
      chk("stall_hold_result", out_result, 3);
      chk("stall_hold_in_ready", in_ready, 0);
    end
    in_valid = 0;
    out_ready = 1;
    issue(2'd0, 32'd5, 32'd3, 6'd24, 5'd4, 32'd15, 0);
    issue(2'd0, 32'd6, 32'd3, 6'd25, 5'd5, 32'd18, 0);
    repeat (8) @(posedge clock);

    // bubble collapse
    @(negedge clock);
    out_ready = 0;
    issue(2'd0, 32'd5, 32'd5, 6'd40, 5'd5, 32'd25, 0);
    repeat (2) @(posedge clock);
    issue(2'd0, 32'd9, 32'd9, 6'd41, 5'd6, 32'd81, 0);
    repeat (4) @(posedge clock);
    @(negedge clock); #1;
    chk("bub_busy", busy_cnt, 2);
    chk("bub_in_ready", in_ready, 1);
    chk("bub_head_tag", out_tag, 40);
    chk("bub_head_result", out_result, 25);
    out_ready = 1;
    @(negedge clock); #1;
    chk("bub_next_valid", out_valid, 1);
    chk("bub_next_tag", out_tag, 41);
    repeat (4) @(posedge clock);

    // squash with three ops in flight and an op offered in the squash cycle
    @(negedge clock);
    out_ready = 0;
    for (int i = 0; i < 3; i++)
      issue(2'd0, 32'd2, 32'd2, 6'(50 + i), 5'(i), 32'd4, 0);
    @(negedge clock);
    in_valid = 1; squash = 1; in_func = 0; in_rs1 = 3; in_rs2 = 3; in_tag = 53; in_rob = 3;
    @(posedge clock);
    #1;
    squash = 0; in_valid = 0;
    repeat (3) void'(sb.pop_back());
    @(negedge clock); #1;
    chk("sq_busy", busy_cnt, 0);
    chk("sq_out_valid", out_valid, 0);
    chk("sq_in_ready", in_ready, 1);
    out_ready = 1;
    repeat (6) @(negedge clock);
    #1;
    chk("sq_quiet", out_valid, 0);

    // squash in the same cycle the head handshakes: result still delivered
    issue(2'd0, 32'd3, 32'd4, 6'd55, 5'd7, 32'd12, 1);
    repeat (3) @(posedge clock);
    @(negedge clock);
    squash = 1;
    #1;
    chk("sqhs_valid", out_valid, 1);
    @(posedge clock);
    #1;
    squash = 0;
    @(negedge clock); #1;
    chk("sqhs_busy", busy_cnt, 0);
    chk("sqhs_out_valid", out_valid, 0);

    // asynchronous reset mid-stream
    out_ready = 0;
    issue(2'd0, 32'd1, 32'd1, 6'd60, 5'd8, 32'd1, 0);
    issue(2'd0, 32'd1, 32'd1, 6'd61, 5'd9, 32'd1, 0);
    repeat (3) @(posedge clock);
    @(negedge clock); #1;
    chk("pre_rst_valid", out_valid, 1);
    #2;
    reset = 0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_busy", busy_cnt, 0);
    repeat (2) void'(sb.pop_back());
    @(negedge clock);
    reset = 1;
    out_ready = 1;
    #1;
    chk("arst_in_ready", in_ready, 1);

    // sweep: same vectors on 1/2/8-stage copies
    sw_issue(2'd0, 32'd7, 32'd6, 6'd33, 5'd2, 32'd42);
    repeat (10) @(posedge clock);
    sw_issue(2'd1, 32'hFFFFFFFF, 32'h2, 6'd10, 5'd10, 32'hFFFFFFFF);
    sw_issue(2'd2, 32'hFFFFFFFF, 32'h2, 6'd11, 5'd11, 32'hFFFFFFFF);
    sw_issue(2'd3, 32'hFFFFFFFF, 32'h2, 6'd12, 5'd12, 32'h00000001);
    sw_issue(2'd0, 32'hFFFFFFFF, 32'h2, 6'd13, 5'd13, 32'hFFFFFFFE);
    sw_issue(2'd2, 32'h80000000, 32'h80000000, 6'd15, 5'd15, 32'hC0000000);
    repeat (12) @(posedge clock);
    @(negedge clock); #3;
    chk("sw1_drained", g_sw[0].q.size(), 0);
    chk("sw2_drained", g_sw[1].q.size(), 0);
    chk("sw8_drained", g_sw[2].q.size(), 0);
    chk("sw1_busy", g_sw[0].bc, 0);
    chk("sw2_busy", g_sw[1].bc, 0);
    chk("sw8_busy", g_sw[2].bc, 0);
    chk("sb_drained", sb.size(), 0);
    chk("final_busy", busy_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
